// File: rtl/writeback_arbiter.sv
// Purpose : merges ALU and MEM results into one in-order queue that drains onto the register file write port.
// Latency : result accepted at edge k into an empty queue is presented (wenable=1) after edge k+1.
// Backpres: ready is derived from occupancy only; same-cycle pops are not credited, MEM has priority over ALU.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   mem_valid/ready/rd/data : MEM result handshake (higher priority, older instruction)
//   alu_valid/ready/rd/data : ALU result handshake
//   wenable/reg_in/din  : registered register-file write port, one write per cycle
//   a/b, pend_a/pend_b  : decode read indices and "write still pending" flags
//   count               : queue occupancy (entries not yet moved to the write port)
module writeback_arbiter #(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [N-1:0]             mem_rd,
    input  logic [WIDTH-1:0]         mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [N-1:0]             alu_rd,
    input  logic [WIDTH-1:0]         alu_data,
    output logic                     wenable,
    output logic [N-1:0]             reg_in,
    output logic [WIDTH-1:0]         din,
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
    output logic                     pend_a,
    output logic                     pend_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Queue storage; contents need no reset because occupancy is tracked by count.
    logic [N-1:0]     rd_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] free;

    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    logic          hit_a;
    logic          hit_b;
    logic [PW-1:0] scan_idx;

    // ------------------------------------------------------------------
    // Acceptance. Free space is judged on the pre-edge occupancy only so
    // ready never depends on whether the write port drains this cycle.
    // When exactly one slot is left, MEM gets it.
    // ------------------------------------------------------------------
    always_comb begin
        free      = DEPTH_C - count;
        mem_ready = !rst && (free >= CW'(1));
        alu_ready = !rst && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));
    end

    // Writes to r0 complete the handshake but are dropped: r0 is hardwired.
    always_comb begin
        mem_push = mem_valid && mem_ready && (mem_rd != '0);
        alu_push = alu_valid && alu_ready && (alu_rd != '0);
        pop      = (count != '0);
        // ALU lands behind MEM when both are enqueued on the same edge.
        alu_slot = mem_push ? (tail + PW'(1)) : tail;
    end

    // ------------------------------------------------------------------
    // Pointer, occupancy and write-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wenable <= 1'b0;
            reg_in  <= '0;
            din     <= '0;
        end else begin
            if (pop) begin
                wenable <= 1'b1;
                reg_in  <= rd_mem[head];
                din     <= data_mem[head];
                head    <= head + PW'(1);
            end else begin
                // reg_in/din hold their last values while idle.
                wenable <= 1'b0;
            end
            tail  <= tail + PW'(mem_push) + PW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Slots written here are always free: pushes are only granted against
    // pre-pop free space, so they never collide with the entry being read.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_mem[tail]   <= mem_rd;
            data_mem[tail] <= mem_data;
        end
        if (alu_push) begin
            rd_mem[alu_slot]   <= alu_rd;
            data_mem[alu_slot] <= alu_data;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write lookup: scan the occupied window head..head+count-1,
    // plus the entry currently sitting on the write port (the register
    // file has not captured it yet).
    // ------------------------------------------------------------------
    always_comb begin
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (rd_mem[scan_idx] == a) hit_a = 1'b1;
                if (rd_mem[scan_idx] == b) hit_b = 1'b1;
            end
        end
        pend_a = (a != '0) && (hit_a || (wenable && (reg_in == a)));
        pend_b = (b != '0) && (hit_b || (wenable && (reg_in == b)));
    end

endmodule
